// File: rtl/arp_stream_arbiter_if.sv
// AXI-Stream bundle carrying LANES independent streams packed side by side.
// The arbiter uses a multi-lane instance for its inputs and a single-lane one for its output.
interface arp_stream_arbiter_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 64,
    parameter int USER_W = 1,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*USER_W-1:0] tuser;
    logic [LANES*ID_W-1:0]   tid;
    logic [LANES*DEST_W-1:0] tdest;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;

    modport master (
        output tdata, tuser, tid, tdest, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tuser, tid, tdest, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/arp_stream_arbiter.sv
// Packet-granular round-robin arbiter: several AXI streams share one ARP parser.
// A grant is locked until the granted input's tlast beat is accepted; one idle cycle per packet.
module arp_stream_arbiter #(
    parameter int  NUM_INPUTS        = 4,
    parameter int  AXIS_BUS_WIDTH    = 64,
    parameter int  AXIS_ID_WIDTH     = 4,
    parameter int  AXIS_DEST_WIDTH   = 0,
    parameter int  MAX_PACKET_LENGTH = 1522,
    localparam int NUM_BUS_BYTES     = AXIS_BUS_WIDTH / 8,
    localparam int EFF_ID_WIDTH      = (AXIS_ID_WIDTH > 1) ? AXIS_ID_WIDTH : 1,
    localparam int EFF_DEST_WIDTH    = (AXIS_DEST_WIDTH > 1) ? AXIS_DEST_WIDTH : 1,
    localparam int TUSER_W           = (2 ** AXIS_ID_WIDTH) + $clog2(MAX_PACKET_LENGTH + 1) + 6,
    localparam int GNT_W             = $clog2(NUM_INPUTS)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    arp_stream_arbiter_if.slave         axis_in,
    arp_stream_arbiter_if.master        axis_out,
    output logic [GNT_W-1:0]            grant_idx,
    output logic                        grant_active
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e           state_q, state_d;
    logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [GNT_W-1:0] pick_idx;
    logic             pick_valid;
    logic             final_beat;

    function automatic logic [GNT_W-1:0] lane_at(input logic [GNT_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return GNT_W'(sum % NUM_INPUTS);
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NUM_INPUTS.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!pick_valid && axis_in.tvalid[lane_at(rr_ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = lane_at(rr_ptr_q, k);
            end
        end
    end

    assign final_beat = axis_in.tvalid[grant_q] & axis_out.tready[0] & axis_in.tlast[grant_q];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (final_beat) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_q == GNT_W'(NUM_INPUTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake gating: nothing moves while idle, only the owner moves while locked.
    always_comb begin
        axis_in.tready  = '0;
        axis_out.tvalid = 1'b0;
        if (state_q == StLocked) begin
            axis_in.tready[grant_q] = axis_out.tready[0];
            axis_out.tvalid         = axis_in.tvalid[grant_q];
        end
    end

    // Payload is a pure mux of the owning input; no buffering on the data path.
    assign axis_out.tdata = axis_in.tdata[int'(grant_q)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
    assign axis_out.tuser = axis_in.tuser[int'(grant_q)*TUSER_W +: TUSER_W];
    assign axis_out.tid   = axis_in.tid[int'(grant_q)*EFF_ID_WIDTH +: EFF_ID_WIDTH];
    assign axis_out.tdest = axis_in.tdest[int'(grant_q)*EFF_DEST_WIDTH +: EFF_DEST_WIDTH];
    assign axis_out.tkeep = axis_in.tkeep[int'(grant_q)*NUM_BUS_BYTES +: NUM_BUS_BYTES];
    assign axis_out.tlast = axis_in.tlast[grant_q];

    assign grant_idx    = grant_q;
    assign grant_active = (state_q == StLocked);

endmodule

// File: tb/tb_arp_stream_arbiter.sv
// Bench for arp_stream_arbiter: directed scenarios then random traffic, checked every cycle
// against a packet-level round-robin model and a per-input beat sequence scoreboard.
module tb_arp_stream_arbiter;
    localparam int N      = 4;
    localparam int W      = 64;
    localparam int IDW    = 4;
    localparam int DESTW  = 0;
    localparam int MAXLEN = 1522;
    localparam int EID    = (IDW > 1) ? IDW : 1;
    localparam int EDEST  = (DESTW > 1) ? DESTW : 1;
    localparam int KB     = W / 8;
    localparam int TU     = (2 ** IDW) + $clog2(MAXLEN + 1) + 6;
    localparam int GW     = $clog2(N);

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [GW-1:0] grant_idx;
    logic          grant_active;

    always #5 aclk = ~aclk;

    arp_stream_arbiter_if #(.LANES(N), .DATA_W(W), .USER_W(TU), .ID_W(EID), .DEST_W(EDEST)) in_if ();
    arp_stream_arbiter_if #(.LANES(1), .DATA_W(W), .USER_W(TU), .ID_W(EID), .DEST_W(EDEST)) out_if ();

    arp_stream_arbiter #(
        .NUM_INPUTS       (N),
        .AXIS_BUS_WIDTH   (W),
        .AXIS_ID_WIDTH    (IDW),
        .AXIS_DEST_WIDTH  (DESTW),
        .MAX_PACKET_LENGTH(MAXLEN)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axis_in     (in_if.slave),
        .axis_out    (out_if.master),
        .grant_idx   (grant_idx),
        .grant_active(grant_active)
    );

    int          errors = 0;
    int          checks = 0;
    int          seq[N], beat[N], len[N], pkts_left[N], out_seq[N];
    int unsigned gap_pct, ostall_pct;
    bit          force_stall, rand_len;
    // Reference model: who owns the output (if anyone) and where the next search starts.
    bit          m_locked;
    int          m_owner, m_rr;
    bit          prev_active;
    int          order[$];
    int          exp_order[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_if.tvalid[i]              = (pkts_left[i] > 0) && ($urandom_range(99) >= gap_pct);
            in_if.tdata[i*W +: W]        = {8'(i), 24'h0, 32'(seq[i])};
            in_if.tuser[i*TU +: TU]      = TU'(seq[i] * 7 + i);
            in_if.tid[i*EID +: EID]      = EID'(i + 5);
            in_if.tdest[i*EDEST +: EDEST] = EDEST'(i);
            in_if.tkeep[i*KB +: KB]      = KB'(beat[i] + 1);
            in_if.tlast[i]               = (beat[i] == len[i] - 1);
        end
        out_if.tready[0] = ($urandom_range(99) >= ostall_pct) && !force_stall;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_grant_active", 64'(grant_active), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("rst_in_tready", 64'(in_if.tready), 64'd0);
        chk("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
    endtask

    task automatic check_cycle();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_locked) exp_rdy[m_owner] = out_if.tready[0];
        chk("grant_active", 64'(grant_active), 64'(m_locked));
        chk("grant_idx", 64'(grant_idx), 64'(m_owner));
        chk("in_tready", 64'(in_if.tready), 64'(exp_rdy));
        chk("out_tvalid", 64'(out_if.tvalid), 64'(m_locked && in_if.tvalid[m_owner]));
        if (m_locked) begin
            chk("out_tdata", out_if.tdata, in_if.tdata[m_owner*W +: W]);
            chk("out_tuser", 64'(out_if.tuser), 64'(in_if.tuser[m_owner*TU +: TU]));
            chk("out_tid", 64'(out_if.tid), 64'(in_if.tid[m_owner*EID +: EID]));
            chk("out_tdest", 64'(out_if.tdest), 64'(in_if.tdest[m_owner*EDEST +: EDEST]));
            chk("out_tkeep", 64'(out_if.tkeep), 64'(in_if.tkeep[m_owner*KB +: KB]));
            chk("out_tlast", 64'(out_if.tlast), 64'(in_if.tlast[m_owner]));
            if (out_if.tvalid[0] && out_if.tready[0]) begin
                chk("beat_seq", {24'h0, out_if.tdata[63:56], out_if.tdata[31:0]},
                    {24'h0, 8'(m_owner), 32'(out_seq[m_owner])});
                out_seq[m_owner]++;
            end
        end
        if (grant_active && !prev_active) order.push_back(int'(grant_idx));
        prev_active = grant_active;
        // Sources advance on their own handshake.
        for (int i = 0; i < N; i++) begin
            if (in_if.tvalid[i] && in_if.tready[i]) begin
                seq[i]++;
                if (in_if.tlast[i]) begin
                    beat[i] = 0;
                    pkts_left[i]--;
                    if (rand_len) len[i] = int'($urandom_range(4, 1));
                end else begin
                    beat[i]++;
                end
            end
        end
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                if (!m_locked && in_if.tvalid[(m_rr + k) % N]) begin
                    m_locked = 1'b1;
                    m_owner  = (m_rr + k) % N;
                end
            end
        end else if (in_if.tvalid[m_owner] && out_if.tready[0] && in_if.tlast[m_owner]) begin
            m_locked = 1'b0;
            m_rr     = (m_owner + 1) % N;
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        check_cycle();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic run_until_done(input int maxc);
        int pending;
        int n;
        n = 0;
        do begin
            cycle();
            n++;
            pending = 0;
            for (int i = 0; i < N; i++) pending += pkts_left[i];
        end while ((pending > 0 || m_locked) && n < maxc);
        chk("drain", 64'(pending + int'(m_locked)), 64'd0);
        cycle();
    endtask

    task automatic check_order(input string tag);
        chk({tag, "_count"}, 64'(order.size()), 64'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < order.size(); i++)
            chk(tag, 64'(order[i]), 64'(exp_order[i]));
        order.delete();
    endtask

    // Called just after a rising edge; reset lands mid-cycle and is checked before the next edge.
    task automatic apply_reset();
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs();
        m_locked    = 1'b0;
        m_owner     = 0;
        m_rr        = 0;
        prev_active = 1'b0;
        for (int i = 0; i < N; i++) begin
            beat[i]      = 0;
            pkts_left[i] = 0;
            out_seq[i]   = seq[i];
        end
        drive();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn     = 1'b0;
        gap_pct     = 0;
        ostall_pct  = 0;
        force_stall = 1'b0;
        rand_len    = 1'b0;
        m_locked    = 1'b0;
        m_owner     = 0;
        m_rr        = 0;
        prev_active = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; beat[i] = 0; len[i] = 1; pkts_left[i] = 0; out_seq[i] = 0;
        end
        drive();
        @(posedge aclk);
        #1;
        chk_reset_outputs();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        drive();

        // Inputs 0 and 2 request together after reset: 0 first, then 2.
        len[0] = 2; len[2] = 2;
        pkts_left[0] = 1; pkts_left[2] = 1;
        run_until_done(40);
        exp_order = '{0, 2};
        check_order("order_simul");

        // All four continuously valid with 3-beat packets, starting fresh from input 0.
        apply_reset();
        for (int i = 0; i < N; i++) len[i] = 3;
        pkts_left[0] = 2; pkts_left[1] = 1; pkts_left[2] = 1; pkts_left[3] = 1;
        run_until_done(60);
        exp_order = '{0, 1, 2, 3, 0};
        check_order("order_all4");

        // Input 3 raises tvalid while input 1 holds the grant.
        len[1] = 4; pkts_left[1] = 1;
        repeat (3) cycle();
        len[3] = 2; pkts_left[3] = 1;
        run_until_done(40);
        exp_order = '{1, 3};
        check_order("order_intrude");

        // Output back-pressure for five cycles in the middle of a packet.
        len[0] = 6; pkts_left[0] = 1;
        repeat (3) cycle();
        force_stall = 1'b1;
        repeat (5) cycle();
        force_stall = 1'b0;
        run_until_done(40);
        exp_order = '{0};
        check_order("order_stall");

        // Sole requester 3 with single-beat packets; the pointer must wrap back to 0.
        len[3] = 1; pkts_left[3] = 1;
        run_until_done(20);
        len[0] = 1; pkts_left[0] = 1; pkts_left[3] = 1;
        run_until_done(20);
        len[1] = 1; pkts_left[1] = 1;
        run_until_done(20);
        exp_order = '{3, 0, 3, 1};
        check_order("order_wrap");

        // Reset during beat 2 of 4 on input 2; afterwards input 0 wins despite rr pointing at 2.
        len[2] = 4; pkts_left[2] = 1;
        repeat (3) cycle();
        apply_reset();
        order.delete();
        len[0] = 2; len[2] = 2; len[3] = 2;
        pkts_left[0] = 1; pkts_left[2] = 1; pkts_left[3] = 1;
        run_until_done(60);
        exp_order = '{0, 2, 3};
        check_order("order_after_reset");

        // Random traffic: valid gaps, output stalls, random packet lengths.
        gap_pct    = 20;
        ostall_pct = 30;
        rand_len   = 1'b1;
        for (int i = 0; i < N; i++) begin
            len[i]       = int'($urandom_range(4, 1));
            pkts_left[i] = int'($urandom_range(8, 3));
        end
        run_until_done(3000);
        order.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
